// File: rtl/div_hilo_ctrl.sv
// rtl/div_hilo_ctrl.sv - EX-stage divide launcher and HI/LO register owner
module div_hilo_ctrl #(
    parameter int           W        = 32,
    parameter logic [W-1:0] HILO_RST = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ex_div_req,
    input  logic           ex_div_sign,
    input  logic [W-1:0]   ex_a,
    input  logic [W-1:0]   ex_b,
    input  logic           ex_mthi,
    input  logic           ex_mtlo,
    input  logic [W-1:0]   ex_wdata,
    input  logic           flush,
    output logic           div_valid,
    output logic           div_sign,
    output logic [W-1:0]   div_a,
    output logic [W-1:0]   div_b,
    input  logic           div_busy,
    input  logic [2*W-1:0] div_result,
    output logic           stall_o,
    output logic [W-1:0]   hi_o,
    output logic [W-1:0]   lo_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state;
    logic   cancel;
    // div_busy is not yet valid in the cycle right after the start pulse was sampled
    logic   seen_busy;
    logic   launch;

    assign launch = ex_div_req && !flush && (ex_b != '0);

    always_comb begin
        stall_o = 1'b0;
        case (state)
            S_IDLE:  stall_o = launch;
            S_ISSUE: stall_o = 1'b1;
            S_WAIT:  stall_o = 1'b1;
            S_DONE:  stall_o = 1'b0;
            S_DRAIN: stall_o = ex_div_req;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            div_valid <= 1'b0;
            div_sign  <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            cancel    <= 1'b0;
            seen_busy <= 1'b0;
            hi_o      <= HILO_RST;
            lo_o      <= HILO_RST;
        end else begin
            div_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        div_sign  <= ex_div_sign;
                        div_a     <= ex_a;
                        div_b     <= ex_b;
                        div_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                    if (!flush) begin
                        if (ex_mthi) hi_o <= ex_wdata;
                        if (ex_mtlo) lo_o <= ex_wdata;
                    end
                end
                S_ISSUE: begin
                    seen_busy <= 1'b0;
                    if (flush) begin
                        cancel <= 1'b1;
                        state  <= S_DRAIN;
                    end else begin
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        // one WAIT cycle has already elapsed, so busy is trustworthy in DRAIN
                        cancel    <= 1'b1;
                        seen_busy <= 1'b1;
                        state     <= S_DRAIN;
                    end else if (seen_busy && !div_busy) begin
                        if (!cancel) begin
                            hi_o <= div_result[2*W-1:W];
                            lo_o <= div_result[W-1:0];
                        end
                        state <= S_DONE;
                    end else begin
                        seen_busy <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!flush) begin
                        if (ex_mthi) hi_o <= ex_wdata;
                        if (ex_mtlo) lo_o <= ex_wdata;
                    end
                    state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (seen_busy && !div_busy) begin
                        cancel <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        seen_busy <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb/tb_div_hilo_ctrl.sv - scoreboard bench for div_hilo_ctrl with a behavioural divider
module tb_div_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_req, ex_div_sign, ex_mthi, ex_mtlo, flush;
    logic [31:0] ex_a, ex_b, ex_wdata;
    logic        div_valid, div_sign, div_busy, stall_o;
    logic [31:0] div_a, div_b, hi_o, lo_o;
    logic [63:0] div_result;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_hilo_ctrl #(.W(32), .HILO_RST(32'h0)) dut (
        .clk(clk), .rst(rst),
        .ex_div_req(ex_div_req), .ex_div_sign(ex_div_sign),
        .ex_a(ex_a), .ex_b(ex_b),
        .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo), .ex_wdata(ex_wdata),
        .flush(flush),
        .div_valid(div_valid), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_result(div_result),
        .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    // Divider model: samples div_valid, raises busy one edge later, busy for 5 cycles.
    logic               pend, fin, fin_d;
    int                 cnt;
    logic               m_sign;
    logic signed [31:0] m_a, m_b;
    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0; div_busy <= 1'b0; fin <= 1'b0; fin_d <= 1'b0; cnt <= 0;
            div_result <= 64'h0;
        end else begin
            fin_d <= fin;
            fin   <= 1'b0;
            if (div_valid) begin
                pend <= 1'b1; m_sign <= div_sign; m_a <= div_a; m_b <= div_b;
            end else if (pend) begin
                pend <= 1'b0; div_busy <= 1'b1; cnt <= 5;
            end else if (div_busy) begin
                if (cnt == 1) begin
                    div_busy <= 1'b0;
                    fin      <= 1'b1;
                    if (m_sign)
                        div_result <= {m_a % m_b, m_a / m_b};
                    else
                        div_result <= {$unsigned(m_a) % $unsigned(m_b), $unsigned(m_a) / $unsigned(m_b)};
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one cycle after the divider finishes, HI/LO must hold the queued result.
    always @(negedge clk) begin
        if (div_valid) pulses++;
        if (fin_d && !rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 64'h1, 64'h0);
            end else begin
                check("hilo_result", {hi_o, lo_o}, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!stall_o) begin ok = 1'b1; break; end
        end
        if (!ok) check({name, "_timeout"}, 64'h0, 64'h1);
        cyc();
    endtask

    task automatic do_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_e, input logic [31:0] lo_e);
        ex_div_req = 1'b1; ex_div_sign = s; ex_a = a; ex_b = b;
        exp_q.push_back({hi_e, lo_e});
        @(negedge clk);
        check({name, "_stall_req"}, {63'h0, stall_o}, 64'h1);
        @(negedge clk);
        check({name, "_issue"}, {62'h0, div_valid, stall_o}, 64'h3);
        wait_done(name);
    endtask

    initial begin
        rst = 1'b1; ex_div_req = 0; ex_div_sign = 0; ex_a = 0; ex_b = 0;
        ex_mthi = 0; ex_mtlo = 0; ex_wdata = 0; flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hilo", {hi_o, lo_o}, 64'h0);
        check("reset_ctl", {61'h0, div_valid, stall_o, div_sign}, 64'h0);
        check("reset_ops", {div_a, div_b}, 64'h0);
        cyc();
        rst = 1'b0;
        cyc();

        do_div("div_7_2", 1'b1, 32'd7, 32'd2, 32'h1, 32'h3);
        do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF);
        ex_div_req = 1'b0;
        cyc();

        // MTHI, then divide by zero must leave HI alone and never launch
        ex_mthi = 1'b1; ex_wdata = 32'h12345678;
        cyc();
        ex_mthi = 1'b0;
        @(negedge clk);
        check("mthi", {32'h0, hi_o}, {32'h0, 32'h12345678});
        cyc();
        ex_div_req = 1'b1; ex_div_sign = 1'b1; ex_a = 32'd5; ex_b = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("divzero_ctl", {62'h0, div_valid, stall_o}, 64'h0);
            cyc();
        end
        ex_div_req = 1'b0;
        @(negedge clk);
        check("divzero_hilo", {hi_o, lo_o}, {32'h12345678, 32'hFFFFFFFF});
        cyc();

        // DIV 100/3 flushed in the third WAIT cycle, DIVU 9/4 arrives during DRAIN
        ex_div_req = 1'b1; ex_div_sign = 1'b1; ex_a = 32'd100; ex_b = 32'd3;
        exp_q.push_back({32'h12345678, 32'hFFFFFFFF});
        repeat (4) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0; ex_div_req = 1'b0;
        @(negedge clk);
        check("flush_stall_drop", {63'h0, stall_o}, 64'h0);
        cyc();
        ex_div_req = 1'b1; ex_div_sign = 1'b0; ex_a = 32'd9; ex_b = 32'd4;
        exp_q.push_back({32'h1, 32'h2});
        @(negedge clk);
        check("drain_stall", {62'h0, div_valid, stall_o}, 64'h1);
        wait_done("divu_9_4");

        // Back-to-back with the request held through DONE
        do_div("b2b_divu_20_6", 1'b0, 32'd20, 32'd6, 32'h2, 32'h3);
        do_div("b2b_div_m20_6", 1'b1, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 32'hFFFFFFFD);
        ex_div_req = 1'b0;
        repeat (3) cyc();

        // Reset while waiting on the divider
        ex_div_req = 1'b1; ex_div_sign = 1'b1; ex_a = 32'd50; ex_b = 32'd5;
        repeat (3) cyc();
        rst = 1'b1; ex_div_req = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_wait_hilo", {hi_o, lo_o}, 64'h0);
        check("rst_wait_ctl", {62'h0, div_valid, stall_o}, 64'h0);
        repeat (10) cyc();

        check("pulse_count", 64'(pulses), 64'd8);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
